// File: rtl/icache_arb_pkg.sv
// Shared types and helpers for the icache line-refill arbiter.
package icache_arb_pkg;

  // Arbiter FSM state. Plain 2-bit constants keep the encoding visible to
  // older blocks that decode the state directly.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t REQ  = 2'd1;
  localparam arb_state_t RSP  = 2'd2;

  // Widest binary index (index bits + none-valid flag) the helpers support.
  localparam int unsigned IDX_MAX_W = 6;

  // All-ones "no owner" index. Slice the low ID_WIDTH+1 bits at the use site.
  localparam logic [IDX_MAX_W-1:0] IDLE_IDX = '1;

  // Onehot to binary encoder. The OR-reduction is only meaningful for a
  // onehot or all-zero input; all-zero encodes to 0.
  function automatic int unsigned oh2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/icache_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo REQ_NUM.
// Rotates the request vector down by ptr with a double-width shift, isolates
// the lowest set bit, then rotates the result back up by ptr.
module icache_rr_pick #(
  parameter int unsigned REQ_NUM = 4,
  localparam int unsigned ID_WIDTH = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [REQ_NUM-1:0]  winner,
  output logic                any_vld
);

  logic [REQ_NUM-1:0] rot;
  logic [REQ_NUM-1:0] pri;

  // Rotate down so bit 0 of rot is the requester at ptr.
  assign rot = REQ_NUM'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the highest-priority request.
  assign pri = rot & (~rot + 1'b1);

  // Rotate back up; the upper half of the doubled vector holds the result.
  assign winner = REQ_NUM'({pri, pri} << ptr >> REQ_NUM);

  assign any_vld = |req;

endmodule

// File: rtl/icache_refill_arb.sv
// Round-robin arbiter for the icache line-refill port. The winner keeps the
// port from request through its final response beat; the grant is exported
// both onehot and as a binary index with a none-valid flag in the MSB.
module icache_refill_arb
  import icache_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned ID_WIDTH  = $clog2(REQ_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_NUM-1:0]                  req_vld,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]  req_addr,
  output logic [REQ_NUM-1:0]                  req_rdy,
  output logic                                mem_req_vld,
  input  logic                                mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr,
  output logic [ID_WIDTH-1:0]                 mem_req_id,
  input  logic                                mem_rsp_vld,
  input  logic                                mem_rsp_last,
  output logic [REQ_NUM-1:0]                  grant_onehot,
  output logic [ID_WIDTH:0]                   grant_idx,
  output logic                                rsp_done,
  output logic                                busy,
  output logic                                proto_err
);

  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQ_NUM - 1);

  arb_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [REQ_NUM-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    proto_err_q, proto_err_d;

  logic [REQ_NUM-1:0]      pick;
  logic                    pick_vld;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [ID_WIDTH-1:0]     grant_id;

  icache_rr_pick #(
    .REQ_NUM (REQ_NUM)
  ) u_pick (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .winner  (pick),
    .any_vld (pick_vld)
  );

  // Winner address via AND-OR mux on the onehot pick.
  always_comb begin
    pick_addr = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      pick_addr = pick_addr | (req_addr[i] & {ADDR_WIDTH{pick[i]}});
    end
  end

  // Binary owner index, derived from the registered onehot grant.
  assign grant_id = ID_WIDTH'(oh2bin(32'(grant_q)));

  // Next-state, accept pulse and completion pulse.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    proto_err_d = proto_err_q;
    req_rdy     = '0;
    rsp_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          req_rdy = pick;
          grant_d = pick;
          addr_d  = pick_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        // Pointer moves only once memory has taken the request.
        if (mem_req_rdy) begin
          rr_ptr_d   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          beat_cnt_d = '0;
          state_d    = RSP;
        end
      end
      RSP: begin
        if (mem_rsp_vld) begin
          // BEATS is a power of two, so the counter wraps naturally.
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (mem_rsp_last != (beat_cnt_q == LAST_BEAT)) begin
            proto_err_d = 1'b1;
          end
          // Termination follows last only, even when the count disagrees.
          if (mem_rsp_last) begin
            rsp_done = 1'b1;
            grant_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Beats are only expected while a refill is outstanding.
    if (mem_rsp_vld && (state_q != RSP)) begin
      proto_err_d = 1'b1;
    end

    // Reset is asynchronous; keep the combinational accept quiet while held.
    if (rst) begin
      req_rdy = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req_vld  = (state_q == REQ);
  assign mem_req_addr = addr_q;
  assign mem_req_id   = grant_id;
  assign grant_onehot = grant_q;
  assign grant_idx    = (state_q == IDLE) ? IDLE_IDX[ID_WIDTH:0] : {1'b0, grant_id};
  assign busy         = (state_q != IDLE);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_icache_refill_arb.sv
// Randomized bench for icache_refill_arb against a transaction-level model.
module tb_icache_refill_arb;

  localparam int N     = 4;
  localparam int BEATS = 4;
  localparam int AW    = 32;
  localparam int IW    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_vld;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         req_rdy;
  logic                 mem_req_vld;
  logic                 mem_req_rdy;
  logic [AW-1:0]        mem_req_addr;
  logic [IW-1:0]        mem_req_id;
  logic                 mem_rsp_vld;
  logic                 mem_rsp_last;
  logic [N-1:0]         grant_onehot;
  logic [IW:0]          grant_idx;
  logic                 rsp_done;
  logic                 busy;
  logic                 proto_err;

  icache_refill_arb #(
    .REQ_NUM    (N),
    .BEATS      (BEATS),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_addr     (req_addr),
    .req_rdy      (req_rdy),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_req_id   (mem_req_id),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_last (mem_rsp_last),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .rsp_done     (rsp_done),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0 = free, 1 = request offered to memory,
  // 2 = collecting beats. Owner, fairness pointer and beats seen as integers.
  int            m_phase, m_ptr, m_owner, m_beats;
  bit            m_err;
  logic [AW-1:0] m_addr;

  // Stimulus knobs and requester/responder bookkeeping.
  logic [N-1:0]         drop, preset, raise_mask;
  logic [N-1:0][AW-1:0] preset_addr;
  int raise_pct, rdy_pct, rsp_pct, stray_pct, hold_off, bad_at, sent;
  int cyc, done_cnt, last_done_cyc, last_grant_cyc;
  int grants[$];

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_beats = 0; m_err = 0; m_addr = '0;
    sent = 0; bad_at = -1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (preset[i]) begin
        req_vld[i] = 1'b1; req_addr[i] = preset_addr[i]; preset[i] = 1'b0;
      end else if (drop[i]) begin
        req_vld[i] = 1'b0; drop[i] = 1'b0;
      end else if (!req_vld[i] && raise_mask[i] && int'($urandom_range(99)) < raise_pct) begin
        req_vld[i] = 1'b1; req_addr[i] = $urandom() & 32'hFFFF_FFC0;
      end
    end
    if (m_phase == 1 && hold_off > 0) begin
      mem_req_rdy = 1'b0; hold_off--;
    end else begin
      mem_req_rdy = int'($urandom_range(99)) < rdy_pct;
    end
    mem_rsp_vld = 1'b0; mem_rsp_last = 1'b0;
    if (m_phase == 2) begin
      if (int'($urandom_range(99)) < rsp_pct) begin
        mem_rsp_vld  = 1'b1;
        mem_rsp_last = (sent == ((bad_at >= 0) ? bad_at : BEATS - 1));
      end
    end else if (int'($urandom_range(99)) < stray_pct) begin
      mem_rsp_vld = 1'b1; mem_rsp_last = 1'($urandom_range(1));
    end
  endtask

  // Compare every output against the model, then advance the model.
  task automatic check_and_step();
    logic [N-1:0] exp_rdy;
    int win;
    exp_rdy = '0; win = -1;
    cyc++;
    if (m_phase == 0 && !rst) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && req_vld[c]) win = c;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_rdy", req_rdy, exp_rdy);
    check("busy", busy, m_phase != 0);
    check("grant_onehot", grant_onehot, (m_phase != 0) ? (1 << m_owner) : 0);
    check("grant_idx", grant_idx, (m_phase != 0) ? m_owner : (1 << (IW + 1)) - 1);
    check("mem_req_vld", mem_req_vld, m_phase == 1);
    if (m_phase == 1) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_id", mem_req_id, m_owner);
    end
    check("rsp_done", rsp_done, m_phase == 2 && mem_rsp_vld && mem_rsp_last);
    check("proto_err", proto_err, m_err);

    // Observations from the DUT for ordering/latency checks.
    if (req_rdy != '0) begin
      for (int i = 0; i < N; i++) if (req_rdy[i]) grants.push_back(i);
      last_grant_cyc = cyc;
    end
    if (rsp_done) begin
      done_cnt++; last_done_cyc = cyc;
    end

    if (rst) return;
    if (win >= 0) drop[win] = 1'b1;
    if (mem_rsp_vld && m_phase != 2) m_err = 1;
    case (m_phase)
      0: if (win >= 0) begin
        m_owner = win; m_addr = req_addr[win]; m_phase = 1;
      end
      1: if (mem_req_rdy) begin
        m_ptr = (m_owner + 1) % N; m_beats = 0; sent = 0; m_phase = 2;
      end
      default: if (mem_rsp_vld) begin
        if (mem_rsp_last != (m_beats == BEATS - 1)) m_err = 1;
        m_beats = (m_beats + 1) % BEATS;
        sent++;
        if (mem_rsp_last) begin
          m_phase = 0; bad_at = -1;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_and_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset between edges and confirm outputs drop without a clock edge.
  task automatic apply_reset_async();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_mem_req_vld", mem_req_vld, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_mem_req_id", mem_req_id, 0);
    check("rst_grant_onehot", grant_onehot, 0);
    check("rst_grant_idx", grant_idx, 3'b111);
    check("rst_rsp_done", rsp_done, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
    req_vld = '0; drop = '0; preset = '0;
    mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic quiesce();
    bit ok;
    ok = 0; raise_mask = '0; rdy_pct = 100; rsp_pct = 100; stray_pct = 0; hold_off = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      cycle();
      ok = (m_phase == 0) && (req_vld == '0) && (preset == '0);
    end
    check("quiesce_done", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int d0;
    bit hit;
    rst = 1'b1;
    req_vld = '0; req_addr = '0; mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_last = 1'b0;
    drop = '0; preset = '0; preset_addr = '0; raise_mask = '0;
    raise_pct = 0; rdy_pct = 100; rsp_pct = 100; stray_pct = 0; hold_off = 0;
    cyc = 0; done_cnt = 0; last_done_cyc = 0; last_grant_cyc = 0;
    model_reset();
    @(negedge clk);
    check_and_step();
    @(posedge clk); #1 rst = 1'b0;

    // Single requester at 0x1000.
    preset[2] = 1'b1; preset_addr[2] = 32'h1000;
    run(10);
    check("single_grant", (grants.size() > 0) ? grants[0] : -1, 2);
    check("single_done", done_cnt, 1);

    // Round-robin fairness with all four requesting.
    apply_reset_async();
    grants.delete();
    raise_mask = '1; raise_pct = 100;
    for (int i = 0; i < 100 && grants.size() < 5; i++) cycle();
    for (int i = 0; i < 5; i++) check("rr_order", (grants.size() > i) ? grants[i] : -1, exp_order[i]);
    quiesce();

    // Backpressure on the memory request.
    preset[1] = 1'b1; preset_addr[1] = 32'h2040;
    hold_off = 5;
    d0 = done_cnt;
    run(16);
    check("bp_done", done_cnt - d0, 1);

    // Early last on the second beat.
    preset[0] = 1'b1; preset_addr[0] = 32'h0880;
    bad_at = 1;
    d0 = done_cnt;
    run(10);
    check("perr_set", proto_err, 1);
    check("perr_done_once", done_cnt - d0, 1);
    run(5);
    check("perr_sticky", proto_err, 1);

    // Reset after the first response beat; pointer must restart at 0.
    apply_reset_async();
    preset[2] = 1'b1; preset_addr[2] = 32'h3000;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (m_phase == 2) && (m_beats == 1);
    end
    check("mid_rsp_reached", hit, 1);
    apply_reset_async();
    grants.delete();
    preset[1] = 1'b1; preset_addr[1] = 32'h4000;
    preset[3] = 1'b1; preset_addr[3] = 32'h5000;
    stray_pct = 100;
    cycle();
    stray_pct = 0;
    check("rst_ptr_grant", (grants.size() > 0) ? grants[0] : -1, 1);
    run(10);
    check("stray_err", proto_err, 1);

    // Requester 3 arrives while requester 0 owns the port.
    apply_reset_async();
    quiesce();
    preset[0] = 1'b1; preset_addr[0] = 32'h6000;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      hit = (m_phase == 2);
    end
    check("busy_rsp_reached", hit, 1);
    preset[3] = 1'b1; preset_addr[3] = 32'h7000;
    grants.delete();
    for (int i = 0; i < 40 && grants.size() == 0; i++) cycle();
    check("busy_grant", (grants.size() > 0) ? grants[0] : -1, 3);
    check("busy_gap", last_grant_cyc - last_done_cyc, 1);
    quiesce();

    // Randomized traffic with occasional protocol faults and resets.
    for (int r = 0; r < 16; r++) begin
      raise_mask = '1;
      raise_pct  = int'($urandom_range(80, 10));
      rdy_pct    = int'($urandom_range(100, 20));
      rsp_pct    = int'($urandom_range(100, 30));
      stray_pct  = (r % 5 == 4) ? 3 : 0;
      if (r % 3 == 2 && m_phase != 2) bad_at = int'($urandom_range(BEATS, 0));
      run(120);
      if (r % 4 == 3) apply_reset_async();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
